id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the pc_plus4, rs_data, rt_data and imm_ext fields.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 in_valid  input  1  decode stage presents a valid instruction.
REQ-005 in_ready  output  1  stage can accept the decode payload this cycle.
REQ-006 in_pc_plus4, in_rs_data, in_rt_data, in_imm_ext  input  DATA_WIDTH each  decode operands; in_imm_ext is the sign/zero-extended immediate.
REQ-007 in_rt_addr, in_rd_addr  input  5 each  register specifiers.
REQ-008 in_alu_op  input  3  ALU operation code.
REQ-009 in_ctrl  input  7  {branch, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write}.
REQ-010 flush  input  1  kill all held instructions (branch taken or exception).
REQ-011 out_valid  output  1  execute-side payload valid.
REQ-012 out_ready  input  1  execute stage accepts the payload.
REQ-013 out_* (pc_plus4, rs_data, rt_data, imm_ext, rt_addr, rd_addr, alu_op, ctrl)  output  widths as inputs  registered payload.

Function
REQ-014 A transfer in SHALL occur when in_valid && in_ready at a rising edge; a transfer out SHALL occur when out_valid && out_ready.
REQ-015 Latency SHALL be exactly one cycle from transfer in to out_valid when the stage is empty.
REQ-016 Every out_* signal SHALL be driven directly from a register; no combinational path from in_* to out_*.
REQ-017 While out_valid && !out_ready, out_* SHALL hold stable.
REQ-018 Simultaneous transfer out and transfer in SHALL replace the held entry with no bubble (full throughput).
REQ-019 flush SHALL clear all valid bits at the next edge and discard any transfer in at that edge; flush has priority over load.
REQ-020 in_ready SHALL be high while flush is high.
REQ-021 When out_valid is low, out_ctrl SHALL read 0 so that reg_write/mem_write cannot be acted on from a bubble.
REQ-022 Payload registers of an invalid entry SHALL NOT update, to avoid needless toggling.

Reset
REQ-023 On reset: out_valid=0, all out_* payload=0, skid entry invalid and 0, in_ready=1 after the first edge following reset release.
REQ-024 Reset asserted mid-transfer SHALL discard both entries; no partial payload SHALL survive.

Configuration
REQ-025 Macro ID_EX_SKID_EN defined: a second (skid) entry SHALL be present; in_ready SHALL be a registered signal equal to "skid entry empty"; a transfer in during !out_ready SHALL land in the skid entry; the skid entry SHALL move to the main entry on the next transfer out.
REQ-026 Macro ID_EX_SKID_EN undefined: single entry only; in_ready SHALL be combinational = !out_valid || out_ready.
REQ-027 Observable ordering, payload and flush behaviour SHALL be identical in both builds; only in_ready timing differs.

Structure
REQ-028 ALU op codes (including 3'h5 ORI and 3'h6 ANDI), ctrl-bit positions and the ctrl width SHALL live in the shared package mips_pkg.
REQ-029 The two-entry storage SHALL be a sub-module id_ex_skid_buffer, parameterised on total payload width; the top level only packs and unpacks fields and applies ctrl gating.

Verification
REQ-030 Reset then one transfer in (in_imm_ext=32'hFFFF_FFF0, alu_op=3'h2, ctrl=7'h43), out_ready=1 -> out_valid=1 next cycle with identical fields, out_valid=0 the cycle after.
REQ-031 Back-to-back 8 instructions, out_ready=1 constantly -> 8 consecutive out_valid cycles, in order, no bubbles.
REQ-032 out_ready=0 for 3 cycles while in_valid=1 -> out_* stable; with ID_EX_SKID_EN exactly 2 accepted and in_ready=0 thereafter; without it exactly 1 accepted; all delivered in order after out_ready=1.
REQ-033 flush asserted with stage full and in_valid=1 -> next cycle out_valid=0 and out_ctrl=0; the flushed-cycle input never appears.
REQ-034 reset pulsed asynchronously mid-cycle while full -> out_valid and payload 0 immediately, before the next clock edge.
REQ-035 Random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> no loss, duplication or reordering of unflushed instructions.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode encodings (ALU op codes, control-bit layout, widths)
package mips_pkg;
    localparam int CTRL_W     = 7;
    localparam int ALU_OP_W   = 3;
    localparam int REG_ADDR_W = 5;

    // Bit positions inside ctrl = {branch, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write}
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 5;
    localparam int CTRL_BRANCH     = 6;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 3'h0,
        ALU_SUB  = 3'h1,
        ALU_AND  = 3'h2,
        ALU_OR   = 3'h3,
        ALU_SLT  = 3'h4,
        ALU_ORI  = 3'h5,
        ALU_ANDI = 3'h6,
        ALU_NOR  = 3'h7
    } alu_op_e;

    function automatic int id_ex_payload_w(input int dw);
        return 4 * dw + 2 * REG_ADDR_W + ALU_OP_W + CTRL_W;
    endfunction
endpackage

// File: rtl/id_ex_skid_buffer.sv
// id_ex_skid_buffer: valid/ready pipeline register; ID_EX_SKID_EN adds a skid entry
// so in_ready becomes a registered signal (skid entry empty).
module id_ex_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_valid = r_valid;
    assign o_data  = r_data;

`ifdef ID_EX_SKID_EN
    logic         r_s_valid;
    logic         r_ready;
    logic [W-1:0] r_s_data;
    logic         w_in;
    logic         w_out;
    logic         w_s_valid_nxt;

    assign o_ready       = r_ready || i_flush;
    assign w_in          = i_valid && r_ready && !i_flush;
    assign w_out         = r_valid && i_ready;
    // Skid fills only when main is held and cannot drain; it empties on the next drain.
    assign w_s_valid_nxt = r_s_valid ? !w_out : (r_valid && !w_out && w_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_ready   <= 1'b0;
        end else if (i_flush) begin
            r_valid   <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_s_valid <= w_s_valid_nxt;
            r_ready   <= !w_s_valid_nxt;
            if (r_s_valid) begin
                if (w_out) r_data <= r_s_data;
            end else if (w_in && (!r_valid || w_out)) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (w_in) begin
                r_s_data <= i_data;
            end else if (w_out) begin
                r_valid <= 1'b0;
            end
        end
    end
`else
    logic w_in;

    assign o_ready = !r_valid || i_ready || i_flush;
    assign w_in    = i_valid && o_ready && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_in) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
`endif
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with valid/ready handshake and flush.
// Build option ID_EX_SKID_EN selects the two-entry skid storage.
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc_plus4,
    input  logic [DATA_WIDTH-1:0] in_rs_data,
    input  logic [DATA_WIDTH-1:0] in_rt_data,
    input  logic [DATA_WIDTH-1:0] in_imm_ext,
    input  logic [4:0]            in_rt_addr,
    input  logic [4:0]            in_rd_addr,
    input  logic [2:0]            in_alu_op,
    input  logic [6:0]            in_ctrl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc_plus4,
    output logic [DATA_WIDTH-1:0] out_rs_data,
    output logic [DATA_WIDTH-1:0] out_rt_data,
    output logic [DATA_WIDTH-1:0] out_imm_ext,
    output logic [4:0]            out_rt_addr,
    output logic [4:0]            out_rd_addr,
    output logic [2:0]            out_alu_op,
    output logic [6:0]            out_ctrl
);
    localparam int PW = id_ex_payload_w(DATA_WIDTH);

    logic [PW-1:0]     w_in_data;
    logic [PW-1:0]     w_out_data;
    logic [CTRL_W-1:0] w_ctrl;

    assign w_in_data = {in_pc_plus4, in_rs_data, in_rt_data, in_imm_ext,
                        in_rt_addr, in_rd_addr, in_alu_op, in_ctrl};

    id_ex_skid_buffer #(.W(PW)) u_buf (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_data),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_data)
    );

    assign {out_pc_plus4, out_rs_data, out_rt_data, out_imm_ext,
            out_rt_addr, out_rd_addr, out_alu_op, w_ctrl} = w_out_data;
    // A bubble must never carry reg_write/mem_write to execute.
    assign out_ctrl = out_valid ? w_ctrl : '0;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: vector table, corner sequences and random traffic against a queue model.
module tb_id_ex_stage_reg;
    typedef struct packed {
        logic [31:0] pc, rs, rt, imm;
        logic [4:0]  rta, rda;
        logic [2:0]  op;
        logic [6:0]  ctrl;
    } pl_t;
    typedef struct {
        pl_t  d;
        logic iv, ordy, fl, exp_ov;
    } vec_t;
    localparam int PW = $bits(pl_t);
`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    pl_t din = '0, dout;
    logic [31:0] o_pc, o_rs, o_rt, o_imm;
    logic [4:0]  o_rta, o_rda;
    logic [2:0]  o_op;
    logic [6:0]  o_ctrl;
    pl_t  q[$];
    vec_t tbl[9];
    int checks = 0, errors = 0, ov_seen = 0, acc_seen = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus4(din.pc), .in_rs_data(din.rs), .in_rt_data(din.rt), .in_imm_ext(din.imm),
        .in_rt_addr(din.rta), .in_rd_addr(din.rda), .in_alu_op(din.op), .in_ctrl(din.ctrl),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_plus4(o_pc), .out_rs_data(o_rs), .out_rt_data(o_rt), .out_imm_ext(o_imm),
        .out_rt_addr(o_rta), .out_rd_addr(o_rda), .out_alu_op(o_op), .out_ctrl(o_ctrl)
    );

    assign dout = {o_pc, o_rs, o_rt, o_imm, o_rta, o_rda, o_op, o_ctrl};

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic chkp(input string n, input pl_t a, input pl_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic pl_t rnd();
        return PW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic pl_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] op, input logic [6:0] ctrl);
        return {pc, pc ^ 32'h1111_1111, pc ^ 32'h2222_2222, imm, pc[4:0], pc[9:5], op, ctrl};
    endfunction

    // One clock: compare DUT against the model at negedge, then advance the model at posedge.
    task automatic cycle();
        logic rdy, acc, fire;
        @(negedge clk);
        rdy = flush || (CAP == 2 ? q.size() < 2 : (q.size() == 0 || out_ready));
        chk1("in_ready", in_ready, rdy);
        chk1("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chkp("payload", dout, q[0]);
        else chk1("bubble_ctrl", |o_ctrl, 1'b0);
        if (out_valid) ov_seen++;
        if (in_valid && in_ready) acc_seen++;
        acc  = in_valid && rdy && !flush;
        fire = q.size() != 0 && out_ready;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(din);
        end
        #1;
    endtask

    task automatic drive(input pl_t d, input logic iv, input logic ordy, input logic fl);
        din = d;
        in_valid = iv;
        out_ready = ordy;
        flush = fl;
    endtask

    initial begin
        int s;
        tbl[0] = '{mk(32'h0000_0104, 32'hFFFF_FFF0, 3'h2, 7'h43), 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{mk(32'h0000_0108, 32'h0000_0001, 3'h0, 7'h01), 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{mk(32'h0000_010C, 32'h0000_00FF, 3'h5, 7'h11), 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{mk(32'h0000_0110, 32'h0000_0002, 3'h1, 7'h7F), 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{mk(32'h0000_0114, 32'h0000_0003, 3'h3, 7'h21), 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{mk(32'h0000_0118, 32'h8000_0000, 3'h6, 7'h14), 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{mk(32'h0000_011C, 32'h0000_0004, 3'h4, 7'h45), 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{mk(32'h0000_0120, 32'h0000_0005, 3'h7, 7'h09), 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{mk(32'h0000_0124, 32'h0000_0006, 3'h2, 7'h02), 1'b0, 1'b1, 1'b0, 1'b0};

        #2;
        chk1("reset_out_valid", out_valid, 1'b0);
        chkp("reset_payload", dout, '0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk1("post_reset_in_ready", in_ready, 1'b1);

        foreach (tbl[i]) begin
            drive(tbl[i].d, tbl[i].iv, tbl[i].ordy, tbl[i].fl);
            cycle();
            chk1($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
        end

        s = ov_seen;
        for (int i = 0; i < 8; i++) begin
            drive(rnd(), 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive('0, 1'b0, 1'b1, 1'b0);
        cycle();
        chki("b2b_valid_cycles", ov_seen - s, 8);

        s = acc_seen;
        for (int i = 0; i < 3; i++) begin
            drive(rnd(), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        chki("stall_accepts", acc_seen - s, CAP);
        drive('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();

        drive(mk(32'h0000_0200, 32'h1, 3'h0, 7'h7F), 1'b1, 1'b0, 1'b0);
        cycle();
        drive(mk(32'h0000_0204, 32'h2, 3'h1, 7'h7F), 1'b1, 1'b0, 1'b1);
        cycle();
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_out_ctrl", |o_ctrl, 1'b0);
        drive('0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();

        drive(mk(32'h0000_0300, 32'hDEAD_BEEF, 3'h6, 7'h55), 1'b1, 1'b0, 1'b0);
        cycle();
        drive(mk(32'h0000_0304, 32'hCAFE_F00D, 3'h5, 7'h2A), 1'b1, 1'b0, 1'b0);
        cycle();
        drive('0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk1("async_reset_out_valid", out_valid, 1'b0);
        chkp("async_reset_payload", dout, '0);
        #1 reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk1("async_reset_in_ready", in_ready, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            drive(rnd(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            cycle();
        end
        drive('0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
